// File: rtl/color_region_tracker.sv
// Per-frame colored-pixel count and bounding box over a highlighted video stream.
// Optional box overlay on the pass-through video when COLOR_TRACK_OVERLAY_EN is defined.
module color_region_tracker #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        box_valid,
  output logic [9:0]  box_x0,
  output logic [9:0]  box_x1,
  output logic [9:0]  box_y0,
  output logic [9:0]  box_y1,
  output logic [18:0] pix_count,
  output logic        found
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 19;

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  state_t state_q, state_d;

  logic [XW-1:0] x_q, cur_x, x_nxt;
  logic [YW-1:0] y_q, cur_y, y_nxt;
  logic          x_last, y_last;
  logic          colored;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic          acc_init, acc_upd, report;

  // Position of the incoming pixel; sof forces (0,0)
  always_comb begin
    cur_x  = in_sof ? '0 : x_q;
    cur_y  = in_sof ? '0 : y_q;
    x_last = (cur_x == XW'(H_ACTIVE - 1));
    y_last = (cur_y == YW'(V_ACTIVE - 1));
    x_nxt  = x_last ? '0 : cur_x + XW'(1);
    y_nxt  = cur_y;
    if (x_last) begin
      y_nxt = y_last ? '0 : cur_y + YW'(1);
    end
    colored = in_valid && !((in_r == in_g) && (in_g == in_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_valid) begin
      x_q <= x_nxt;
      y_q <= y_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and accumulator control
  always_comb begin
    state_d  = state_q;
    acc_init = 1'b0;
    acc_upd  = 1'b0;
    report   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          state_d  = ACTIVE;
          acc_init = 1'b1;
          acc_upd  = 1'b1;
        end
      end
      ACTIVE: begin
        if (in_valid) begin
          acc_upd  = 1'b1;
          acc_init = in_sof;
          if (!in_sof && x_last && y_last) begin
            state_d = REPORT;
            report  = 1'b1;
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
        if (in_valid && in_sof) begin
          state_d  = ACTIVE;
          acc_init = 1'b1;
          acc_upd  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator update including the current pixel
  always_comb begin
    cnt_d   = acc_init ? '0        : cnt_q;
    min_x_d = acc_init ? '1        : min_x_q;
    max_x_d = acc_init ? '0        : max_x_q;
    min_y_d = acc_init ? '1        : min_y_q;
    max_y_d = acc_init ? '0        : max_y_q;
    if (acc_upd && colored) begin
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CW'(1);
      end
      if (cur_x < min_x_d) min_x_d = cur_x;
      if (cur_x > max_x_d) max_x_d = cur_x;
      if (cur_y < min_y_d) min_y_d = cur_y;
      if (cur_y > max_y_d) max_y_d = cur_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      min_x_q <= '1;
      max_x_q <= '0;
      min_y_q <= '1;
      max_y_q <= '0;
    end else if (acc_upd) begin
      cnt_q   <= cnt_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
    end
  end

  // Result latch; an empty frame reports an all-zero box
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid <= 1'b0;
      box_x0    <= '0;
      box_x1    <= '0;
      box_y0    <= '0;
      box_y1    <= '0;
      pix_count <= '0;
      found     <= 1'b0;
    end else begin
      box_valid <= report;
      if (report) begin
        pix_count <= cnt_d;
        found     <= (cnt_d >= CW'(MIN_COUNT));
        if (cnt_d == '0) begin
          box_x0 <= '0;
          box_x1 <= '0;
          box_y0 <= '0;
          box_y1 <= '0;
        end else begin
          box_x0 <= min_x_d;
          box_x1 <= max_x_d;
          box_y0 <= min_y_d;
          box_y1 <= max_y_d;
        end
      end
    end
  end

  logic [7:0] pix_r_c, pix_g_c, pix_b_c;

`ifdef COLOR_TRACK_OVERLAY_EN
  logic in_cols, in_rows, on_box_c;

  // Outline of the previously latched box
  always_comb begin
    in_cols  = (cur_x >= box_x0) && (cur_x <= box_x1);
    in_rows  = (cur_y >= box_y0) && (cur_y <= box_y1);
    on_box_c = found && in_valid &&
               ((in_cols && ((cur_y == box_y0) || (cur_y == box_y1))) ||
                (in_rows && ((cur_x == box_x0) || (cur_x == box_x1))));
    pix_r_c  = on_box_c ? 8'hFF : in_r;
    pix_g_c  = on_box_c ? 8'h00 : in_g;
    pix_b_c  = on_box_c ? 8'hFF : in_b;
  end
`else
  always_comb begin
    pix_r_c = in_r;
    pix_g_c = in_g;
    pix_b_c = in_b;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      out_valid <= in_valid;
      out_r     <= pix_r_c;
      out_g     <= pix_g_c;
      out_b     <= pix_b_c;
    end
  end

endmodule

// File: tb/tb_color_region_tracker.sv
// Directed bench for color_region_tracker on an 8x4 frame with MIN_COUNT=2.
module tb_color_region_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof;
  logic [7:0]  in_r, in_g, in_b;
  logic        out_valid;
  logic [7:0]  out_r, out_g, out_b;
  logic        box_valid;
  logic [9:0]  box_x0, box_x1, box_y0, box_y1;
  logic [18:0] pix_count;
  logic        found;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  color_region_tracker #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_COUNT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .box_valid(box_valid), .box_x0(box_x0), .box_x1(box_x1),
    .box_y0(box_y0), .box_y1(box_y1), .pix_count(pix_count), .found(found)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] map;
    logic [7:0]  gray;
    logic [7:0]  cr, cg, cb;
    int          cnt, x0, x1, y0, y1;
    logic        fnd;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One pixel per call; entered and left at a falling edge
  task automatic drive_px(input logic v, input logic sof, input logic [7:0] r, g, b);
    in_valid = v; in_sof = sof; in_r = r; in_g = g; in_b = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_px(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic send_frame(input vec_t t, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps && (i == 3 || i == 12)) begin
        drive_px(1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        drive_px(1'b0, 1'b1, 8'h11, 8'h22, 8'h33);
      end
      if (t.map[i]) drive_px(1'b1, i == 0, t.cr, t.cg, t.cb);
      else          drive_px(1'b1, i == 0, t.gray, t.gray, t.gray);
    end
  endtask

  task automatic check_report(input string tag, input vec_t t);
    check({tag, "_box_valid"}, box_valid, 1);
    check({tag, "_pix_count"}, pix_count, t.cnt);
    check({tag, "_x0"}, box_x0, t.x0);
    check({tag, "_x1"}, box_x1, t.x1);
    check({tag, "_y0"}, box_y0, t.y0);
    check({tag, "_y1"}, box_y1, t.y1);
    check({tag, "_found"}, found, t.fnd);
  endtask

  // Reference for the one-cycle pass-through path
  logic       exp_v;
  logic [7:0] exp_r, exp_g, exp_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_v <= 1'b0; exp_r <= 8'h00; exp_g <= 8'h00; exp_b <= 8'h00;
    end else begin
      exp_v <= in_valid; exp_r <= in_r; exp_g <= in_g; exp_b <= in_b;
    end
  end

`ifndef COLOR_TRACK_OVERLAY_EN
  always @(negedge clk) begin
    if (rst_n) check("passthru", {out_valid, out_r, out_g, out_b}, {exp_v, exp_r, exp_g, exp_b});
  end
`endif

  always @(posedge clk) begin
    if (box_valid) pulses++;
  end

  initial begin
    int p0;
    logic [7:0] ov_r, ov_g, ov_b;
    vecs[0] = '{32'h0000_0000, 8'h40, 8'd255, 8'd0, 8'd0,   0, 0, 0, 0, 0, 1'b0};
    vecs[1] = '{32'h2000_0400, 8'h40, 8'd255, 8'd0, 8'd0,   2, 2, 5, 1, 3, 1'b1};
    vecs[2] = '{32'h0000_0080, 8'h00, 8'd10,  8'd10, 8'd11, 1, 7, 7, 0, 0, 1'b0};
    vecs[3] = '{32'h8000_0001, 8'hFF, 8'd7,   8'd8, 8'd7,   2, 0, 7, 0, 3, 1'b1};
    vecs[4] = '{32'h00FF_0000, 8'h80, 8'd0,   8'd0, 8'd255, 8, 0, 7, 2, 2, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_r = 8'h00; in_g = 8'h00; in_b = 8'h00;
    @(negedge clk);
    drive_px(1'b1, 1'b1, 8'd255, 8'd0, 8'd0);
    drive_px(1'b1, 1'b0, 8'd255, 8'd0, 8'd0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rgb", {out_r, out_g, out_b}, 0);
    check("rst_box_valid", box_valid, 0);
    check("rst_coords", {box_x0, box_x1, box_y0, box_y1}, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_found", found, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Table of isolated frames
    for (int k = 0; k < 5; k++) begin
      p0 = pulses;
      send_frame(vecs[k], 1'b0);
      check_report($sformatf("vec%0d", k), vecs[k]);
      idle(2);
      check($sformatf("vec%0d_pulse_cnt", k), pulses - p0, 1);
      check($sformatf("vec%0d_bv_low", k), box_valid, 0);
      check($sformatf("vec%0d_hold_cnt", k), pix_count, vecs[k].cnt);
    end

    // Colored pixels before the first sof, and gaps mid-line
    p0 = pulses;
    for (int i = 0; i < 5; i++) drive_px(1'b1, 1'b0, 8'd255, 8'd0, 8'd0);
    send_frame(vecs[1], 1'b1);
    check_report("gaps", vecs[1]);
    idle(2);
    check("gaps_pulse_cnt", pulses - p0, 1);

    // Abort: restart with sof at (4,2); (0,0) and (1,0) of the aborted frame are dropped
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      if (i < 2) drive_px(1'b1, i == 0, 8'd0, 8'd255, 8'd0);
      else       drive_px(1'b1, 1'b0, 8'h40, 8'h40, 8'h40);
    end
    send_frame(vecs[1], 1'b0);
    check_report("abort", vecs[1]);
    idle(2);
    check("abort_pulse_cnt", pulses - p0, 1);

    // Back-to-back frames: sof arrives in the report cycle
    p0 = pulses;
    send_frame(vecs[3], 1'b0);
    check_report("b2b_a", vecs[3]);
    send_frame(vecs[1], 1'b0);
    check_report("b2b_b", vecs[1]);
    idle(2);
    check("b2b_pulse_cnt", pulses - p0, 2);

    // Gray frame under a latched box (2,1)-(5,3)
`ifdef COLOR_TRACK_OVERLAY_EN
    ov_r = 8'hFF; ov_g = 8'h00; ov_b = 8'hFF;
`else
    ov_r = 8'h40; ov_g = 8'h40; ov_b = 8'h40;
`endif
    for (int i = 0; i < 32; i++) begin
      drive_px(1'b1, i == 0, 8'h40, 8'h40, 8'h40);
      if (i == 11) check("ovl_3_1", {out_valid, out_r, out_g, out_b}, {1'b1, ov_r, ov_g, ov_b});
      if (i == 18) check("ovl_2_2", {out_valid, out_r, out_g, out_b}, {1'b1, ov_r, ov_g, ov_b});
      if (i == 19) check("ovl_3_2", {out_valid, out_r, out_g, out_b}, {1'b1, 8'h40, 8'h40, 8'h40});
    end
    check_report("ovl", vecs[0]);
    idle(2);

    // Reset mid-frame after a non-zero result
    send_frame(vecs[4], 1'b0);
    check_report("pre_rst", vecs[4]);
    idle(2);
    for (int i = 0; i < 10; i++) drive_px(1'b1, i == 0, 8'd255, 8'd0, 8'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_rgb", {out_r, out_g, out_b}, 0);
    check("mid_rst_pix_count", pix_count, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_coords", {box_x0, box_x1, box_y0, box_y1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 40; i++) drive_px(1'b1, 1'b0, 8'd255, 8'd0, 8'd0);
    idle(3);
    check("post_rst_no_report", pulses - p0, 0);
    check("post_rst_pix_count", pix_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
